md_scheduler: RTL
=================

Name: md_scheduler

Overview:
Owns the HI/LO registers and sequences multi-cycle MULT/MULTU/DIV/DIVU issued from the E stage.
Holds each operation's result for a fixed latency, then commits it to HI/LO.
Raises a D-stage stall for any HI/LO-class instruction while an operation is starting or in flight.
Its stall output is ORed with the hazard stall at top level; it sits beside the E-stage ALU.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
e_md_op  input  3  E-stage operation code (encoding in package)
e_rs_data  input  32  E-stage forwarded rs operand
e_rt_data  input  32  E-stage forwarded rt operand
d_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  output  1  operation in flight
md_stall  output  1  stall request for the D stage
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset, asynchronous: hi=0, lo=0, busy=0, internal counter=0, pending result=0. md_stall=0 whenever busy=0 and e_md_op is not a start op.
- Start ops are MULT/MULTU/DIV/DIVU. A start is accepted on a clk edge when e_md_op is a start op and busy=0.
- On acceptance: the 64-bit result is computed from the operands present in that cycle and latched as pending. Counter loads MULT_CYCLES or DIV_CYCLES. busy goes to 1.
- While busy: counter decrements each edge. On the edge where counter goes 1->0, busy clears and hi/lo take the pending value.
- busy is therefore high for exactly N cycles after the start cycle. New hi/lo values are visible the cycle busy falls.
- MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: the full busy period still runs; hi/lo are left unchanged at commit.
- MTHI/MTLO: hi/lo take e_rs_data on the next edge; busy is unaffected.
- md_stall = d_md_use && (busy || e_md_op is a start op). This is combinational, with no extra latency.
- Start op while busy: ignored, with no state change. Unreachable in the pipeline because of md_stall.
- MTHI/MTLO while busy: the write happens, and the later commit overwrites both registers. Unreachable in the pipeline.
- MTHI and commit on the same edge: commit wins for both hi and lo.
- Reset mid-operation: the pending result is discarded; busy=0 and hi/lo=0 immediately.
- Op codes 7 and NONE: no effect.

Decomposition:
- Package md_pkg holds:
  - op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6;
  - counter width constant MD_CNT_W=4;
  - helper predicate is_start_op.
- One combinational sub-module md_alu: inputs op, a, b; outputs 64-bit {hi,lo} result and a div_by_zero flag.
- Sequencing, counter, HI/LO and stall logic stay in md_scheduler.

Test Plan:
- MULT, rs=0xFFFFFFFD (-3), rt=5: busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV, rs=0xFFFFFFF9 (-7), rt=2: busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands: lo=0x7FFFFFFC, hi=1.
- d_md_use=1 in the start cycle and during busy: md_stall=1 from the start cycle through the last busy cycle, 0 the cycle busy falls. d_md_use=0 during busy: md_stall=0 throughout.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0: hi/lo update one edge after each op; busy stays 0. Then DIV with rt=0: busy 10 cycles, and hi/lo still hold those values afterward.
- Reset asserted between edges at cycle 3 of a MULT: hi=lo=0 and busy=0 without waiting for a clock edge; the next MULT 2*3 yields lo=6 after 5 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. A start op during busy is ignored and the original result commits.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: operation
// encoding, scheduler states, counter width and the start-op predicate.
package md_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_start_op(input logic [2:0] op);
        logic start;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: start = 1'b1;
            default:                            start = 1'b0;
        endcase
        return start;
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational 32x32 multiply/divide datapath producing {hi,lo}.
// Signed divide works on magnitudes so the INT_MIN / -1 case needs no special path.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic        signed_div_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Product, quotient and remainder selection for the requested operation
    always_comb begin
        signed_div_s = (op == MD_DIV);
        abs_a_s      = (signed_div_s && a[31]) ? (32'd0 - a) : a;
        abs_b_s      = (signed_div_s && b[31]) ? (32'd0 - b) : b;
        result       = 64'd0;
        div_by_zero  = 1'b0;
        if (b == 32'd0) begin
            quo_s = 32'd0;
            rem_s = 32'd0;
        end else begin
            quo_s = abs_a_s / abs_b_s;
            rem_s = abs_a_s % abs_b_s;
        end
        case (op)
            MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            MD_MULTU: result = {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                result[63:32] = a[31] ? (32'd0 - rem_s) : rem_s;
                result[31:0]  = (a[31] ^ b[31]) ? (32'd0 - quo_s) : quo_s;
                div_by_zero   = (b == 32'd0);
            end
            MD_DIVU: begin
                result      = {rem_s, quo_s};
                div_by_zero = (b == 32'd0);
            end
            default: result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO owner: latches a multi-cycle MULT/DIV result at start, commits it after a
// fixed latency, and stalls D-stage HI/LO users while an operation starts or runs.
module md_scheduler
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_md_op,
    input  logic [31:0] e_rs_data,
    input  logic [31:0] e_rt_data,
    input  logic        d_md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e             state_r, state_next_s;
    logic [MD_CNT_W-1:0]   cnt_r, cnt_next_s;
    logic [63:0]           pend_r, pend_next_s;
    logic                  pend_dz_r, pend_dz_next_s;
    logic [31:0]           hi_r, hi_next_s;
    logic [31:0]           lo_r, lo_next_s;
    logic [63:0]           alu_result_s;
    logic                  alu_dz_s;
    logic                  start_s;

    md_alu u_alu (
        .op          (e_md_op),
        .a           (e_rs_data),
        .b           (e_rt_data),
        .result      (alu_result_s),
        .div_by_zero (alu_dz_s)
    );

    // Next-state, counter, pending result and HI/LO update
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        pend_next_s    = pend_r;
        pend_dz_next_s = pend_dz_r;
        hi_next_s      = hi_r;
        lo_next_s      = lo_r;
        start_s        = is_start_op(e_md_op) && (state_r == MD_IDLE);

        case (e_md_op)
            MD_MTHI: hi_next_s = e_rs_data;
            MD_MTLO: lo_next_s = e_rs_data;
            default: hi_next_s = hi_r;
        endcase

        case (state_r)
            MD_IDLE: begin
                if (start_s) begin
                    state_next_s   = MD_BUSY;
                    cnt_next_s     = ((e_md_op == MD_MULT) || (e_md_op == MD_MULTU))
                                     ? MD_CNT_W'(MULT_CYCLES) : MD_CNT_W'(DIV_CYCLES);
                    pend_next_s    = alu_result_s;
                    pend_dz_next_s = alu_dz_s;
                end else begin
                    state_next_s   = MD_IDLE;
                end
            end
            MD_BUSY: begin
                // A commit overrides any same-edge MTHI/MTLO; a divide by zero keeps them
                if (cnt_r <= MD_CNT_W'(1)) begin
                    state_next_s = MD_IDLE;
                    cnt_next_s   = {MD_CNT_W{1'b0}};
                    hi_next_s    = pend_dz_r ? hi_next_s : pend_r[63:32];
                    lo_next_s    = pend_dz_r ? lo_next_s : pend_r[31:0];
                end else begin
                    cnt_next_s   = cnt_r - MD_CNT_W'(1);
                end
            end
            default: begin
                state_next_s = MD_IDLE;
                cnt_next_s   = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= MD_IDLE;
            cnt_r     <= {MD_CNT_W{1'b0}};
            pend_r    <= 64'd0;
            pend_dz_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            pend_r    <= pend_next_s;
            pend_dz_r <= pend_dz_next_s;
            hi_r      <= hi_next_s;
            lo_r      <= lo_next_s;
        end
    end

    assign busy     = (state_r == MD_BUSY);
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign md_stall = d_md_use && (busy || is_start_op(e_md_op));

endmodule
